// File: rtl/vga_axi_fb_slave_if.sv
// AXI4-Lite read-only channel bundle (AR + R) between the VGA read master and the frame buffer.
interface vga_axi_fb_slave_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64
);
    logic [AXI_ADDR_WIDTH-1:0] s_araddr_i;
    logic [2:0]                s_arprot_i;
    logic                      s_arvalid_i;
    logic                      s_arrdy_o;
    logic [AXI_DATA_WIDTH-1:0] s_rdata_o;
    logic [1:0]                s_rresp_o;
    logic                      s_rvalid_o;
    logic                      s_rrdy_i;

    modport slave (
        input  s_araddr_i, s_arprot_i, s_arvalid_i, s_rrdy_i,
        output s_arrdy_o, s_rdata_o, s_rresp_o, s_rvalid_o
    );

    modport master (
        output s_araddr_i, s_arprot_i, s_arvalid_i, s_rrdy_i,
        input  s_arrdy_o, s_rdata_o, s_rresp_o, s_rvalid_o
    );
endinterface

// File: rtl/vga_axi_fb_slave.sv
// Frame-buffer AXI4-Lite read responder with a synchronous load port.
// Optional out-of-range SLVERR reporting: define VGA_AXI_FB_SLV_RANGE_CHECK_EN.
module vga_axi_fb_slave #(
    parameter int unsigned               AXI_ADDR_WIDTH = 32,
    parameter int unsigned               AXI_DATA_WIDTH = 64,
    parameter int unsigned               MEM_DEPTH      = 4800,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    vga_axi_fb_slave_if.slave            axi,
    input  logic                         wr_en_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]    wr_data_i
);
    localparam int unsigned OFFS = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned IW   = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A = AXI_ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {StReset, StIdle, StRead, StResp} state_e;

    state_e                    state_q, state_d;
    logic [IW-1:0]             idx_q;
    logic                      in_range_q;
    logic                      zero_q;
    logic [AXI_DATA_WIDTH-1:0] ram_q;
    logic [1:0]                rresp_q;
    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [AXI_ADDR_WIDTH-1:0] word_full;
    logic [IW-1:0]             word_idx;
    logic                      in_range;
    logic                      unused_arprot;

    assign unused_arprot = ^axi.s_arprot_i;
    assign word_full     = (axi.s_araddr_i - BASE_ADDR) >> OFFS;

`ifdef VGA_AXI_FB_SLV_RANGE_CHECK_EN
    assign in_range = (word_full < DEPTH_A) && (axi.s_araddr_i >= BASE_ADDR);
    assign word_idx = IW'(word_full);
`else
    assign in_range = 1'b1;
    assign word_idx = IW'(word_full % DEPTH_A);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: state_d = StIdle;
            StIdle:  if (axi.s_arvalid_i) state_d = StRead;
            StRead:  state_d = StResp;
            StResp:  if (axi.s_rrdy_i) state_d = StIdle;
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReset;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            zero_q     <= 1'b1;
            rresp_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && axi.s_arvalid_i) begin
                idx_q      <= word_idx;
                in_range_q <= in_range;
            end
            if (state_q == StRead) begin
                zero_q  <= !in_range_q;
                rresp_q <= in_range_q ? 2'b00 : 2'b10;
            end
        end
    end

    // RAM read register kept reset-free so it maps onto block RAM; zero_q masks it instead.
    always_ff @(posedge clk) begin
        if (state_q == StRead && in_range_q) begin
            ram_q <= mem[idx_q];
        end
        if (wr_en_i && (32'(wr_addr_i) < MEM_DEPTH)) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign axi.s_arrdy_o  = (state_q == StIdle);
    assign axi.s_rvalid_o = (state_q == StResp);
    assign axi.s_rdata_o  = zero_q ? '0 : ram_q;
    assign axi.s_rresp_o  = rresp_q;
endmodule

// File: tb/tb_vga_axi_fb_slave.sv
// Self-checking bench for vga_axi_fb_slave: directed cases plus randomized reads vs a memory model.
module tb_vga_axi_fb_slave;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 4800;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [12:0] wr_addr = '0;
    logic [63:0] wr_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] model_mem [DEPTH];

    vga_axi_fb_slave_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axi ();

    vga_axi_fb_slave #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .MEM_DEPTH     (DEPTH),
        .BASE_ADDR     (BASE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .axi      (axi),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected response straight from the address rules: word = (addr - base) / bytes-per-word.
    task automatic ref_read(input logic [31:0] addr, output logic [63:0] d, output logic [1:0] r);
        logic [31:0] diff;
        longint unsigned idx;
        diff = addr - BASE;
        idx  = longint'(diff) / 8;
`ifdef VGA_AXI_FB_SLV_RANGE_CHECK_EN
        if (idx >= DEPTH || addr < BASE) begin
            d = '0;
            r = 2'b10;
        end else begin
            d = model_mem[idx];
            r = 2'b00;
        end
`else
        d = model_mem[idx % DEPTH];
        r = 2'b00;
`endif
    endtask

    task automatic load(input int unsigned a, input logic [63:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 13'(a);
        wr_data = d;
        model_mem[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input int stall,
                           input bit collide, input logic [63:0] cdata);
        logic [63:0] exp_d;
        logic [1:0]  exp_r;
        int          cnt;
        int unsigned widx;
        ref_read(addr, exp_d, exp_r);
        widx = (addr - BASE) / 8;
        @(negedge clk);
        axi.s_araddr_i  = addr;
        axi.s_arprot_i  = 3'($urandom);
        axi.s_arvalid_i = 1'b1;
        axi.s_rrdy_i    = 1'b0;
        cnt = 0;
        while (axi.s_arrdy_o !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("%s_arrdy", tag), 64'(axi.s_arrdy_o), 64'd1);
        @(negedge clk);
        axi.s_arvalid_i = 1'b0;
        chk($sformatf("%s_rvalid_read", tag), 64'(axi.s_rvalid_o), 64'd0);
        chk($sformatf("%s_arrdy_read", tag), 64'(axi.s_arrdy_o), 64'd0);
        if (collide) begin
            wr_en   = 1'b1;
            wr_addr = 13'(widx);
            wr_data = cdata;
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            chk($sformatf("%s_rvalid[%0d]", tag, i), 64'(axi.s_rvalid_o), 64'd1);
            chk($sformatf("%s_rdata[%0d]", tag, i), axi.s_rdata_o, exp_d);
            chk($sformatf("%s_rresp[%0d]", tag, i), 64'(axi.s_rresp_o), 64'(exp_r));
            chk($sformatf("%s_arrdy_resp[%0d]", tag, i), 64'(axi.s_arrdy_o), 64'd0);
            if (i < stall) @(negedge clk);
        end
        axi.s_rrdy_i = 1'b1;
        @(negedge clk);
        axi.s_rrdy_i = 1'b0;
        chk($sformatf("%s_rvalid_done", tag), 64'(axi.s_rvalid_o), 64'd0);
        chk($sformatf("%s_arrdy_done", tag), 64'(axi.s_arrdy_o), 64'd1);
        chk($sformatf("%s_rdata_hold", tag), axi.s_rdata_o, exp_d);
        if (collide) model_mem[widx] = cdata;
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        axi.s_araddr_i  = '0;
        axi.s_arprot_i  = '0;
        axi.s_arvalid_i = 1'b0;
        axi.s_rrdy_i    = 1'b0;

        // Reset release
        repeat (5) @(negedge clk);
        chk("rst_arrdy", 64'(axi.s_arrdy_o), 64'd0);
        chk("rst_rvalid", 64'(axi.s_rvalid_o), 64'd0);
        chk("rst_rdata", axi.s_rdata_o, 64'd0);
        chk("rst_rresp", 64'(axi.s_rresp_o), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_arrdy_first", 64'(axi.s_arrdy_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rel_arrdy_second", 64'(axi.s_arrdy_o), 64'd1);
        chk("rel_rvalid", 64'(axi.s_rvalid_o), 64'd0);

        // Fill the whole RAM through the load port
        for (int i = 0; i < int'(DEPTH); i++) begin
            wr_en   = 1'b1;
            wr_addr = 13'(i);
            wr_data = {$urandom, $urandom};
            model_mem[i] = wr_data;
            @(negedge clk);
        end
        wr_en = 1'b0;
        load(3, 64'hDEAD_BEEF_0123_4567);
        load(5, 64'h0);
        load(0, 64'h0BAD_F00D_CAFE_0000);

        do_read("basic", 32'h18, 0, 1'b0, '0);
        do_read("backpressure", 32'h18, 4, 1'b0, '0);
        do_read("unaligned", 32'h1D, 0, 1'b0, '0);
        do_read("range", DEPTH * 8, 1, 1'b0, '0);
        do_read("last_word", (DEPTH - 1) * 8, 0, 1'b0, '0);
        do_read("collide", 32'h28, 0, 1'b1, 64'h1);
        do_read("after_collide", 32'h28, 0, 1'b0, '0);

        // Reset asserted while the response is pending
        @(negedge clk);
        axi.s_araddr_i  = 32'h18;
        axi.s_arvalid_i = 1'b1;
        @(negedge clk);
        axi.s_arvalid_i = 1'b0;
        @(negedge clk);
        chk("midrst_pre_rvalid", 64'(axi.s_rvalid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", 64'(axi.s_rvalid_o), 64'd0);
        chk("midrst_arrdy", 64'(axi.s_arrdy_o), 64'd0);
        chk("midrst_rdata", axi.s_rdata_o, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        axi.s_rrdy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_stale[%0d]", i), 64'(axi.s_rvalid_o), 64'd0);
        end
        axi.s_rrdy_i = 1'b0;

        // Randomized reads against the model
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: a = $urandom_range(0, DEPTH - 1) * 8;
                1: a = $urandom_range(0, DEPTH - 1) * 8 + $urandom_range(1, 7);
                2: a = DEPTH * 8 + $urandom_range(0, 32'h000F_FFFF);
                default: a = $urandom;
            endcase
            if (kind == 0 && n % 5 == 0) begin
                do_read($sformatf("rnd%0d_col", n), a, int'($urandom_range(0, 3)), 1'b1,
                        {$urandom, $urandom});
            end else begin
                do_read($sformatf("rnd%0d", n), a, int'($urandom_range(0, 3)), 1'b0, '0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
